// File: rtl/mem_responder_pkg.sv
// mem_pkg: shared types and defaults for the mem_responder slice.
// The optional feature is selected with the MEM_PARITY_EN macro: when it is
// defined, each word carries an even-parity bit checked on every read.
package mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 12;
  // The wait counter has to hold WAIT_CYCLES, whose legal range is 0..15.
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: strobe/ready bus between the control unit (master) and
// the memory (slave).
// Handshake: the master raises exactly one of mem_read/mem_write with
// addr/wdata valid. The slave samples that request on a rising edge while it
// is idle. After that edge the master may change or drop anything, because
// the request has been latched. The slave pulses mem_ready for one cycle when
// the access has committed, and rdata is valid in that cycle for a read.
// The slave pulses mem_err for one cycle on a fault. A strobe that is still
// high once the slave has returned to idle is taken as a new request.
interface mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) ();

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              mem_ready;
  logic              mem_err;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, mem_ready, mem_err
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, mem_ready, mem_err
  );

endinterface

// File: rtl/mem_responder_array.sv
// mem_array: single-port synchronous word RAM with a registered read port.
// When MEM_PARITY_EN is defined, a parity column is stored beside the data.
// That column holds even parity computed on write, and it is compared
// against the stored data whenever the read register is loaded.
module mem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              par_err
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Array write; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register: loads only on a read and otherwise holds the last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

`ifdef MEM_PARITY_EN
  logic par_mem [2**ADDR_W];

  // Parity column write: the XOR of the data word gives even parity overall.
  always_ff @(posedge clk) begin
    if (we) begin
      par_mem[addr] <= ^wdata;
    end
  end

  // The parity check result is registered alongside the read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      par_err <= 1'b0;
    end else if (re) begin
      par_err <= (par_mem[addr] != (^mem[addr]));
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side end of the CPU's mem_read/mem_write strobes.
// It has an IDLE -> WAIT -> RESP FSM, WAIT_CYCLES programmable wait states
// and a single-cycle mem_ready pulse. Both strobes high at once is a fault
// and is reported on mem_err.
// Optional: MEM_PARITY_EN adds a stored parity bit per word. A parity
// mismatch on a read raises mem_err in the same cycle as mem_ready.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  mem_responder_if.slave   bus,
  output state_t           state_dbg,
  output logic [CNT_W-1:0] cnt_dbg
);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              accept, dual;
  logic              op_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              dual_q;

  logic              enter_resp;
  logic              cur_write;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              arr_we, arr_re;
  logic [DATA_W-1:0] arr_rdata;
  logic              arr_par_err;

  // State, counter and request latches. Reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      dual_q     <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      dual_q <= dual;
      if (accept) begin
        op_write_q <= bus.mem_write;
        addr_q     <= bus.addr;
        wdata_q    <= bus.wdata;
      end
    end
  end

  // Next-state logic: accept a single strobe in IDLE, count down the waits,
  // then spend one cycle in RESP.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    dual       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_read ^ bus.mem_write) begin
          accept     = 1'b1;
          cnt_next   = CNT_W'(WAIT_CYCLES);
          state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end else if (bus.mem_read & bus.mem_write) begin
          dual = 1'b1;
        end
      end
      WAIT: begin
        cnt_next = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The array is accessed on the edge that enters RESP, so mem_ready always
  // means committed. With zero wait states that edge is also the acceptance
  // edge, so in IDLE the live bus is used instead of the latches.
  always_comb begin
    enter_resp = (state_next == RESP) && (state != RESP);
    cur_write  = (state == IDLE) ? bus.mem_write : op_write_q;
    cur_addr   = (state == IDLE) ? bus.addr      : addr_q;
    cur_wdata  = (state == IDLE) ? bus.wdata     : wdata_q;
    arr_we     = enter_resp &  cur_write;
    arr_re     = enter_resp & ~cur_write;
  end

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .we      (arr_we),
    .re      (arr_re),
    .addr    (cur_addr),
    .wdata   (cur_wdata),
    .rdata   (arr_rdata),
    .par_err (arr_par_err)
  );

  assign bus.rdata     = arr_rdata;
  assign bus.mem_ready = (state == RESP);
  assign bus.mem_err   = dual_q | ((state == RESP) & ~op_write_q & arr_par_err);

  assign state_dbg = state;
  assign cnt_dbg   = cnt;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and random accesses on two responders (2 and 0
// wait states). The expected values come from a word-per-address memory
// model and from latency = waits + 1.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int W0 = 2;
  localparam int W1 = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if #(.DATA_W(16), .ADDR_W(12)) bus0 ();
  mem_responder_if #(.DATA_W(16), .ADDR_W(12)) bus1 ();

  state_t     st0, st1;
  logic [3:0] cnt0, cnt1;

  mem_responder #(.DATA_W(16), .ADDR_W(12), .WAIT_CYCLES(W0)) dut (
    .clk(clk), .reset(rst), .bus(bus0), .state_dbg(st0), .cnt_dbg(cnt0));
  mem_responder #(.DATA_W(16), .ADDR_W(12), .WAIT_CYCLES(W1)) dut0 (
    .clk(clk), .reset(rst), .bus(bus1), .state_dbg(st1), .cnt_dbg(cnt1));

  int checks   = 0;
  int failures = 0;

  logic [15:0] model0 [int];
  logic [15:0] model1 [int];
  logic [15:0] last_rd [2];
  logic [15:0] exp_q [$];
  int          waddr0 [$];
  int          waddr1 [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic r, input logic w,
                       input logic [11:0] a, input logic [15:0] d);
    if (sel == 0) begin
      bus0.mem_read = r; bus0.mem_write = w; bus0.addr = a; bus0.wdata = d;
    end else begin
      bus1.mem_read = r; bus1.mem_write = w; bus1.addr = a; bus1.wdata = d;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? bus0.mem_ready : bus1.mem_ready;
  endfunction

  function automatic logic get_err(input int sel);
    return (sel == 0) ? bus0.mem_err : bus1.mem_err;
  endfunction

  function automatic logic [15:0] get_rdata(input int sel);
    return (sel == 0) ? bus0.rdata : bus1.rdata;
  endfunction

  // One access: the request is presented for a single sampling edge. Then
  // addr/wdata are scrambled to alt_a/random while the strobe is dropped,
  // and the bench waits (bounded) for mem_ready.
  task automatic access(input int sel, input bit wr, input logic [11:0] a,
                        input logic [15:0] d, input logic [11:0] alt_a,
                        output int lat, output logic [15:0] rd,
                        output logic err, output logic ready_after);
    logic rdy;
    lat = -1; rd = '0; err = 1'b0; ready_after = 1'b0;
    @(negedge clk);
    drive(sel, !wr, wr, a, d);
    @(posedge clk);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      rdy = get_ready(sel);
      if (rdy) begin
        lat = i; rd = get_rdata(sel); err = get_err(sel);
      end
      if (i == 1) drive(sel, 1'b0, 1'b0, alt_a, 16'($urandom));
      if (rdy) break;
    end
    @(negedge clk);
    ready_after = get_ready(sel);
  endtask

  // Access checked against the model: latency, no error, one-cycle pulse,
  // and read data (or held data after a write).
  task automatic txn(input int sel, input bit wr, input logic [11:0] a,
                     input logic [15:0] d, input logic [11:0] alt_a, input string tag);
    int          lat;
    logic [15:0] rd, exp_rd;
    logic        err, ra;
    if (!wr) exp_q.push_back((sel == 0) ? model0[int'(a)] : model1[int'(a)]);
    access(sel, wr, a, d, alt_a, lat, rd, err, ra);
    check({tag, "_latency"}, lat, (sel == 0) ? W0 + 1 : W1 + 1);
    check({tag, "_err"}, {31'b0, err}, 32'd0);
    check({tag, "_pulse"}, {31'b0, ra}, 32'd0);
    if (wr) begin
      if (sel == 0) model0[int'(a)] = d; else model1[int'(a)] = d;
      exp_rd = last_rd[sel];
    end else begin
      exp_rd = exp_q.pop_front();
      last_rd[sel] = exp_rd;
    end
    check({tag, "_rdata"}, {16'b0, rd}, {16'b0, exp_rd});
  endtask

  initial begin
    int          lat;
    logic [15:0] rd;
    logic        err, ra;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    last_rd[0] = '0; last_rd[1] = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    check("rst_state", int'(st0), int'(IDLE));
    check("rst_cnt", {28'b0, cnt0}, 32'd0);
    check("rst_rdata", {16'b0, bus0.rdata}, 32'd0);
    check("rst_ready", {31'b0, bus0.mem_ready}, 32'd0);
    check("rst_err", {31'b0, bus0.mem_err}, 32'd0);
    check("rst_rdata_w0", {16'b0, bus1.rdata}, 32'd0);

    // Write then read with two wait states.
    txn(0, 1'b1, 12'h010, 16'h1234, 12'h7ff, "wr_010");
    txn(0, 1'b0, 12'h010, 16'h0000, 12'h7ff, "rd_010");

    // Zero wait states.
    txn(1, 1'b1, 12'h000, 16'hbeef, 12'h123, "w0_wr_000");
    txn(1, 1'b0, 12'h000, 16'h0000, 12'h123, "w0_rd_000");

    // Both strobes high: an error pulse, no access.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 12'h010, 16'hffff);
    @(negedge clk);
    check("dual_err", {31'b0, bus0.mem_err}, 32'd1);
    check("dual_ready", {31'b0, bus0.mem_ready}, 32'd0);
    check("dual_state", int'(st0), int'(IDLE));
    drive(0, 1'b0, 1'b0, 12'h010, 16'hffff);
    @(negedge clk);
    check("dual_err_clear", {31'b0, bus0.mem_err}, 32'd0);
    txn(0, 1'b0, 12'h010, 16'h0000, 12'h020, "dual_target");

    // An address change during WAIT does not redirect the read.
    txn(0, 1'b1, 12'h020, 16'h5555, 12'h010, "wr_020");
    txn(0, 1'b0, 12'h010, 16'h0000, 12'h020, "rd_addr_change");

    // Reset during WAIT discards the pending write.
    txn(0, 1'b1, 12'h030, 16'h7777, 12'h031, "wr_030");
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 12'h030, 16'haaaa);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 12'h000, 16'h0000);
    check("mid_state", int'(st0), int'(WAIT));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", int'(st0), int'(IDLE));
    check("abort_cnt", {28'b0, cnt0}, 32'd0);
    check("abort_rdata", {16'b0, bus0.rdata}, 32'd0);
    check("abort_ready", {31'b0, bus0.mem_ready}, 32'd0);
    check("abort_err", {31'b0, bus0.mem_err}, 32'd0);
    last_rd[0] = '0; last_rd[1] = '0;
    txn(0, 1'b0, 12'h030, 16'h0000, 12'h031, "rd_030_old");

    // Random traffic on both responders against the model.
    for (int n = 0; n < 40; n++) begin
      int          sel;
      bit          wr;
      logic [11:0] a;
      sel = int'($urandom_range(0, 1));
      wr  = (sel == 0) ? (waddr0.size() == 0 || $urandom_range(0, 1) == 1)
                       : (waddr1.size() == 0 || $urandom_range(0, 1) == 1);
      if (wr) begin
        a = 12'($urandom_range(0, 4095));
        if (sel == 0) waddr0.push_back(int'(a)); else waddr1.push_back(int'(a));
      end else begin
        a = (sel == 0) ? 12'(waddr0[$urandom_range(0, waddr0.size() - 1)])
                       : 12'(waddr1[$urandom_range(0, waddr1.size() - 1)]);
      end
      txn(sel, wr, a, 16'($urandom), 12'($urandom), wr ? "rnd_wr" : "rnd_rd");
    end

`ifdef MEM_PARITY_EN
    // Corrupt the stored parity of 0x010, then read it back.
    @(negedge clk);
    dut.u_array.par_mem[12'h010] = ~dut.u_array.par_mem[12'h010];
    access(0, 1'b0, 12'h010, 16'h0000, 12'h020, lat, rd, err, ra);
    check("par_latency", lat, W0 + 1);
    check("par_err", {31'b0, err}, 32'd1);
    check("par_rdata", {16'b0, rd}, {16'b0, model0[32'h010]});
    check("par_err_clear", {31'b0, bus0.mem_err}, 32'd0);
`else
    access(0, 1'b0, 12'h010, 16'h0000, 12'h020, lat, rd, err, ra);
    check("plain_rd_err", {31'b0, err}, 32'd0);
    check("plain_rd_data", {16'b0, rd}, {16'b0, model0[32'h010]});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
